// File: rtl/aes_encrypt_iter_if.sv
// Handshake and data bundle for the iterative AES-128 encryptor.
// The master side (requester / key store) drives start, plaintext and
// round_key; the slave side (the encryptor) returns round_idx, status
// and the ciphertext.
interface aes_encrypt_iter_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  modport master (
    output start, plaintext, round_key,
    input  round_idx, busy, done, ciphertext
  );

  modport slave (
    input  start, plaintext, round_key,
    output round_idx, busy, done, ciphertext
  );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock.
// The round key for the current round_idx is supplied combinationally by an
// external key store, so no key expansion lives here. Timing: the start edge
// performs the initial AddRoundKey, rounds 1..NR-1 take one cycle each, and
// the final round (no MixColumns) registers the ciphertext and pulses done.

// Forward AES S-box, table lookup (entry 0 sits in the top byte).
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry x lives at bit offset (255 - x) * 8.
  assign y = SBOX_TBL[{~x, 3'b000} +: 8];
endmodule

module aes_encrypt_iter #(
  parameter int NR = 10
) (
  input logic             clk,
  input logic             rst,
  aes_encrypt_iter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [3:0] LAST_MID = 4'(NR - 1);

  state_t       state_r;
  state_t       state_next_s;
  logic [3:0]   rnd_r;
  logic [127:0] blk_r;
  logic [127:0] ct_r;
  logic         done_r;
  logic         busy_r;
  logic [3:0]   round_idx_s;
  logic [127:0] sub_s;
  logic [127:0] shift_s;
  logic [127:0] round_s;
  logic [127:0] final_s;

  // GF(2^8) multiply by 2 modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the column-major state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  // Each column multiplied by the circulant {02 03 01 01}.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return o;
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .x (blk_r[8*g +: 8]),
      .y (sub_s[8*g +: 8])
    );
  end

  assign shift_s = shift_rows(sub_s);
  assign round_s = mix_columns(shift_s) ^ bus.round_key;
  assign final_s = shift_s ^ bus.round_key;

  // Next-state decode: start launches, the last middle round hands over to FINAL.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = ROUND;
        else           state_next_s = IDLE;
      end
      ROUND: begin
        if (rnd_r == LAST_MID) state_next_s = FINAL;
        else                   state_next_s = ROUND;
      end
      FINAL:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Datapath: round state, round counter, ciphertext and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_r  <= 128'h0;
      ct_r   <= 128'h0;
      rnd_r  <= 4'd0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            blk_r  <= bus.plaintext ^ bus.round_key;
            rnd_r  <= 4'd1;
            busy_r <= 1'b1;
          end else begin
            rnd_r  <= 4'd0;
            busy_r <= 1'b0;
          end
        end
        ROUND: begin
          blk_r  <= round_s;
          rnd_r  <= rnd_r + 4'd1;
          busy_r <= 1'b1;
        end
        FINAL: begin
          ct_r   <= final_s;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          rnd_r  <= 4'd0;
        end
        default: begin
          rnd_r  <= 4'd0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Key-store index: zero while idle, otherwise the live round number.
  always_comb begin
    round_idx_s = 4'd0;
    case (state_r)
      IDLE:    round_idx_s = 4'd0;
      ROUND:   round_idx_s = rnd_r;
      FINAL:   round_idx_s = rnd_r;
      default: round_idx_s = 4'd0;
    endcase
  end

  assign bus.round_idx  = round_idx_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ciphertext = ct_r;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 known-answer vectors, cycle
// timing of round_idx/busy/done, start ignored while busy, back-to-back
// operation with start held, and reset behaviour. The bench expands the key
// itself and serves round keys combinationally from round_idx.
module tb_aes_encrypt_iter;
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic [127:0] rk [0:15];
  logic [127:0] prev_ct;
  int           n_vec;
  int           n_bad;

  aes_encrypt_iter_if bus ();

  aes_encrypt_iter #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External key store: round key follows round_idx combinationally.
  always_comb bus.round_key = rk[bus.round_idx];

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // AES-128 key expansion into rk[0..10].
  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One encryption from the start cycle (cycle 0) to the done cycle (cycle 11).
  // Returns in the done cycle without advancing the clock.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp,
                           input logic hold, input logic spurious, input string tag);
    bus.start     = 1'b1;
    bus.plaintext = pt;
    chk({tag, ".idx0"}, 128'(bus.round_idx), 128'd0);
    tick();
    if (!hold) bus.start = 1'b0;
    bus.plaintext = ~pt;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("%s.idx%0d", tag, k), 128'(bus.round_idx), 128'(k));
      chk($sformatf("%s.busy%0d", tag, k), 128'(bus.busy), 128'd1);
      chk($sformatf("%s.done%0d", tag, k), 128'(bus.done), 128'd0);
      chk($sformatf("%s.hold%0d", tag, k), bus.ciphertext, prev_ct);
      if (spurious && k == 5) begin
        bus.start     = 1'b1;
        bus.plaintext = PT_B;
      end
      if (spurious && k == 6 && !hold) bus.start = 1'b0;
      tick();
    end
    chk({tag, ".done"}, 128'(bus.done), 128'd1);
    chk({tag, ".busy_end"}, 128'(bus.busy), 128'd0);
    chk({tag, ".idx_end"}, 128'(bus.round_idx), 128'd0);
    chk({tag, ".ct"}, bus.ciphertext, exp);
    prev_ct = exp;
  endtask

  // Cycle after a done: pulse over, result held.
  task automatic post_check(input string tag);
    tick();
    chk({tag, ".done_drop"}, 128'(bus.done), 128'd0);
    chk({tag, ".ct_held"}, bus.ciphertext, prev_ct);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    prev_ct = 128'h0;
    for (int i = 0; i < 16; i++) rk[i] = 128'h0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.plaintext = 128'h0;
    tick();
    tick();
    chk("rst.busy", 128'(bus.busy), 128'd0);
    chk("rst.done", 128'(bus.done), 128'd0);
    chk("rst.ct", bus.ciphertext, 128'h0);
    chk("rst.idx", 128'(bus.round_idx), 128'd0);
    rst = 1'b0;
    tick();

    // App. C.1 with full timing checks.
    load_key(KEY_C1);
    run_block(PT_C1, CT_C1, 1'b0, 1'b0, "c1");
    post_check("c1");
    tick();

    // App. B.
    load_key(KEY_B);
    run_block(PT_B, CT_B, 1'b0, 1'b0, "b");
    post_check("b");

    // C.1 again, with a stray start and new plaintext mid-run.
    load_key(KEY_C1);
    run_block(PT_C1, CT_C1, 1'b0, 1'b1, "spur");
    post_check("spur");
    tick();

    // Start held high: C.1, B, C.1 back to back, key swapped in the done cycle.
    run_block(PT_C1, CT_C1, 1'b1, 1'b0, "b2b0");
    load_key(KEY_B);
    run_block(PT_B, CT_B, 1'b1, 1'b0, "b2b1");
    load_key(KEY_C1);
    run_block(PT_C1, CT_C1, 1'b1, 1'b0, "b2b2");
    bus.start = 1'b0;
    post_check("b2b2");

    // Reset mid-encryption: aborted, no done, outputs cleared.
    bus.start = 1'b1;
    bus.plaintext = PT_C1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 128'(bus.busy), 128'd0);
    chk("abort.done", 128'(bus.done), 128'd0);
    chk("abort.ct", bus.ciphertext, 128'h0);
    chk("abort.idx", 128'(bus.round_idx), 128'd0);
    prev_ct = 128'h0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("abort.nodone%0d", k), 128'(bus.done), 128'd0);
    end

    // Start coincident with reset is dropped.
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("rst_start.busy", 128'(bus.busy), 128'd0);
    chk("rst_start.idx", 128'(bus.round_idx), 128'd0);

    // App. B after the abort.
    load_key(KEY_B);
    run_block(PT_B, CT_B, 1'b0, 1'b0, "b_after");
    post_check("b_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
